hash_sequencer: RTL
===================

HASH_SEQUENCER -- requirements
Module: hash_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sets the message-length and pad-length bus width.
REQ-002 Parameter BLOCK_SIZE, default 64, sets the bytes per hash block.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, sets the per-phase watchdog limit and is used only under REQ-030.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port go, input, 1: level request to run one message.
REQ-007 Port msgLen, input, DATA_WIDTH: message length in bytes, sampled on go acceptance.
REQ-008 Port subRst, output, 1: one-cycle clear pulse to the loader, pad and hash sub-blocks.
REQ-009 Ports loadStart, padStart and hashStart, output, 1 each: level start to each sub-block.
REQ-010 Ports loadFinish, padFinish and hashFinish, input, 1 each: sticky finish from each sub-block.
REQ-011 Port padLen, output, DATA_WIDTH: latched msgLen, driven to the pad dataLen.
REQ-012 Port busOwner, output, 2: shared memory bus owner (0 none, 1 loader, 2 pad, 3 hash).
REQ-013 Port done, output, 1: run complete.
REQ-014 Port error, output, 1: run rejected or aborted.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, LOAD, PAD, HASH, DONE and ERROR, and SHALL advance one state per clk at most.
REQ-016 In IDLE with go=1 and msgLen <= BLOCK_SIZE-9, the FSM SHALL latch msgLen into padLen and go to CLEAR.
REQ-017 In IDLE with go=1 and msgLen > BLOCK_SIZE-9, the FSM SHALL go to ERROR; padLen SHALL be unchanged.
REQ-018 CLEAR SHALL assert subRst for exactly one cycle, then go to LOAD.
REQ-019 LOAD SHALL drive loadStart=1 and busOwner=1; on loadFinish=1 it SHALL go to PAD.
REQ-020 PAD SHALL drive padStart=1 and busOwner=2; on padFinish=1 it SHALL go to HASH.
REQ-021 HASH SHALL drive hashStart=1 and busOwner=3; on hashFinish=1 it SHALL go to DONE.
REQ-022 Each start output SHALL be registered, high for every cycle of its phase, and low in the cycle after the matching finish is sampled.
REQ-023 At most one start output SHALL be high in any cycle.
REQ-024 busOwner SHALL be 0 in IDLE, CLEAR, DONE and ERROR.
REQ-025 DONE SHALL hold done=1, and ERROR SHALL hold error=1, until go=0 is sampled, then go to IDLE.
REQ-026 go toggling during CLEAR through HASH SHALL be ignored; the run SHALL continue.
REQ-027 A finish input asserted outside its own phase SHALL be ignored, including a stale finish held from a prior run; subRst in CLEAR guarantees clearance.
REQ-028 The boundary msgLen = BLOCK_SIZE-9 (55 at default) SHALL be accepted, and BLOCK_SIZE-8 SHALL be rejected.

Reset
REQ-029 rst=1 at any clk, including mid-phase, SHALL force IDLE, with subRst, all starts, busOwner, done and error at 0 and padLen at 0 in the next cycle; rst SHALL take priority over all transitions.

Configuration
REQ-030 With macro HASH_SEQ_TIMEOUT_EN defined, a per-phase counter SHALL clear on entry to LOAD, PAD or HASH and increment each cycle in that phase.
REQ-031 If the REQ-030 counter reaches TIMEOUT_CYCLES without the matching finish, the FSM SHALL go to ERROR and drop the start; finish sampled on the limit cycle SHALL win.
REQ-032 Without HASH_SEQ_TIMEOUT_EN, no counter SHALL exist and phases SHALL wait indefinitely.

Verification
REQ-033 Bench SHALL cover: go=1, msgLen=3; each finish 4 cycles after its start -> subRst 1 cycle, busOwner 1->2->3, done=1, padLen=3.
REQ-034 Bench SHALL cover: msgLen=55 -> accepted and reaches DONE; msgLen=56 -> error=1 next cycle, no start asserted.
REQ-035 Bench SHALL cover: padFinish held high from the previous run while entering LOAD -> FSM remains in LOAD until loadFinish.
REQ-036 Bench SHALL cover: rst pulsed during PAD -> next cycle all outputs 0 and IDLE; a new go=1 runs normally.
REQ-037 Bench SHALL cover: with HASH_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=10, hashFinish never asserted -> error=1 after 10 HASH cycles and hashStart=0.
REQ-038 Bench SHALL cover: done=1 with go held high -> done stays 1; go=0 -> IDLE next cycle.

Source files
------------

// File: rtl/hash_sequencer.sv
// ============================================================================
// Module   : hash_sequencer
// Brief    : Runs one message through loader, pad and hash sub-blocks in turn
//            and arbitrates the shared memory bus. Define HASH_SEQ_TIMEOUT_EN
//            to add a per-phase watchdog of TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [DATA_WIDTH-1:0] msgLen,
    output logic                  subRst,
    output logic                  loadStart,
    output logic                  padStart,
    output logic                  hashStart,
    input  logic                  loadFinish,
    input  logic                  padFinish,
    input  logic                  hashFinish,
    output logic [DATA_WIDTH-1:0] padLen,
    output logic [1:0]            busOwner,
    output logic                  done,
    output logic                  error
);

    // Eight bytes of length field plus the 0x80 marker must fit in one block.
    localparam logic [DATA_WIDTH-1:0] c_MAX_LEN = DATA_WIDTH'(BLOCK_SIZE - 9);

    if (BLOCK_SIZE < 9 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("hash_sequencer: BLOCK_SIZE must be >= 9 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_PAD   = 3'd3,
        S_HASH  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_len_latch;
    logic                  w_timeout;
    logic                  r_sub_rst;
    logic                  r_load_start;
    logic                  r_pad_start;
    logic                  r_hash_start;
    logic [1:0]            r_bus_owner;
    logic                  r_done;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_pad_len;

`ifdef HASH_SEQ_TIMEOUT_EN
    localparam int                c_CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    // Holds the 1-based index of the current cycle within the phase.
    logic [c_CNT_W-1:0] r_phase_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_phase_cnt <= c_ONE;
        end else if (r_state == S_LOAD || r_state == S_PAD || r_state == S_HASH) begin
            r_phase_cnt <= r_phase_cnt + c_ONE;
        end
    end

    assign w_timeout = (r_phase_cnt == c_TIMEOUT);
`else
    assign w_timeout = 1'b0;
`endif

    // Finish is tested before the watchdog so a finish on the limit cycle wins.
    always_comb begin
        w_state_next = r_state;
        w_len_latch  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    if (msgLen <= c_MAX_LEN) begin
                        w_state_next = S_CLEAR;
                        w_len_latch  = 1'b1;
                    end else begin
                        w_state_next = S_ERROR;
                    end
                end
            end
            S_CLEAR: w_state_next = S_LOAD;
            S_LOAD: begin
                if (loadFinish)     w_state_next = S_PAD;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_PAD: begin
                if (padFinish)      w_state_next = S_HASH;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_HASH: begin
                if (hashFinish)     w_state_next = S_DONE;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (!go) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sub_rst    <= 1'b0;
            r_load_start <= 1'b0;
            r_pad_start  <= 1'b0;
            r_hash_start <= 1'b0;
            r_bus_owner  <= 2'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_pad_len    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_sub_rst    <= (w_state_next == S_CLEAR);
            r_load_start <= (w_state_next == S_LOAD);
            r_pad_start  <= (w_state_next == S_PAD);
            r_hash_start <= (w_state_next == S_HASH);
            r_done       <= (w_state_next == S_DONE);
            r_error      <= (w_state_next == S_ERROR);
            case (w_state_next)
                S_LOAD:  r_bus_owner <= 2'd1;
                S_PAD:   r_bus_owner <= 2'd2;
                S_HASH:  r_bus_owner <= 2'd3;
                default: r_bus_owner <= 2'd0;
            endcase
            if (w_len_latch) begin
                r_pad_len <= msgLen;
            end
        end
    end

    assign subRst    = r_sub_rst;
    assign loadStart = r_load_start;
    assign padStart  = r_pad_start;
    assign hashStart = r_hash_start;
    assign busOwner  = r_bus_owner;
    assign done      = r_done;
    assign error     = r_error;
    assign padLen    = r_pad_len;

endmodule

`default_nettype wire
